// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
package i2s_pkg;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    SHIFT     = 2'd1,
    HOLD      = 2'd2
  } state_t;

  localparam int MODE_I2S = 0;
  localparam int MODE_LJ  = 1;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_input_sync.sv
// Brings sck/ws/sd into the clk domain and flags each rising edge of sck,
// with ws/sd presented from the same synchronised sample as the edge.
module i2s_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic ws,
  input  logic sd,
  output logic sck_rise,
  output logic ws_smp,
  output logic sd_smp
);

  logic [SYNC_STAGES-1:0] sck_sr;
  logic [SYNC_STAGES-1:0] ws_sr;
  logic [SYNC_STAGES-1:0] sd_sr;
  logic                   sck_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sr   <= '0;
      ws_sr    <= '0;
      sd_sr    <= '0;
      sck_prev <= 1'b0;
      sck_rise <= 1'b0;
      ws_smp   <= 1'b0;
      sd_smp   <= 1'b0;
    end else begin
      sck_sr   <= {sck_sr[SYNC_STAGES-2:0], sck};
      ws_sr    <= {ws_sr[SYNC_STAGES-2:0], ws};
      sd_sr    <= {sd_sr[SYNC_STAGES-2:0], sd};
      // Edge detect stage: ws/sd registered alongside so they line up with sck_rise
      sck_prev <= sck_sr[SYNC_STAGES-1];
      sck_rise <= sck_sr[SYNC_STAGES-1] & ~sck_prev;
      ws_smp   <= ws_sr[SYNC_STAGES-1];
      sd_smp   <= sd_sr[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/i2s_rx_frame.sv
// I2S / left-justified receiver: frames serial bits into left/right PCM words
// and commits each L/R pair atomically with a one-clk sample_valid strobe.
module i2s_rx_frame
  import i2s_pkg::*;
#(
  parameter int SAMPLE_BITS = 16,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sck,
  input  logic                   ws,
  input  logic                   sd,
  output logic [SAMPLE_BITS-1:0] left_data,
  output logic [SAMPLE_BITS-1:0] right_data,
  output logic                   sample_valid,
  output logic                   short_slot
);

  localparam int              CNT_W    = $clog2(SAMPLE_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SAMPLE_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sck_rise;
  logic ws_smp;
  logic sd_smp;

  i2s_input_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .sck     (sck),
    .ws      (ws),
    .sd      (sd),
    .sck_rise(sck_rise),
    .ws_smp  (ws_smp),
    .sd_smp  (sd_smp)
  );

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SAMPLE_BITS-1:0] shreg_q, shreg_d;
  logic                   ch_q, ch_d;
  logic                   ws_prev_q;
  logic                   ws_eff_prev_q;
  logic [SAMPLE_BITS-1:0] hold_q;
  logic                   hold_vld_q;

  logic                   ws_eff;
  logic                   slot_edge;
  logic                   done;
  logic                   done_short;
  logic                   done_ch;
  logic [SAMPLE_BITS-1:0] done_word;

  // A short slot holds n valid bits in the LSBs; move them to the MSBs, zero fill.
  function automatic logic [SAMPLE_BITS-1:0] align_word(
    input logic [SAMPLE_BITS-1:0] w,
    input logic [CNT_W-1:0]       n
  );
    logic [CNT_W-1:0] pad;
    pad = CNT_FULL - n;
    return w << pad;
  endfunction

  // In I2S mode the channel of the current bit is the ws seen one sck earlier.
  assign ws_eff    = (MODE == MODE_LJ) ? ws_smp : ws_prev_q;
  assign slot_edge = sck_rise && (ws_eff != ws_eff_prev_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    ch_d       = ch_q;
    done       = 1'b0;
    done_short = 1'b0;
    done_ch    = ch_q;
    done_word  = '0;
    if (sck_rise) begin
      case (state_q)
        SYNC_WAIT: begin
          if (slot_edge && ws_eff == CH_LEFT) begin
            state_d = SHIFT;
            cnt_d   = CNT_ONE;
            shreg_d = {{(SAMPLE_BITS-1){1'b0}}, sd_smp};
            ch_d    = CH_LEFT;
          end
        end
        SHIFT: begin
          if (slot_edge) begin
            done       = 1'b1;
            done_short = 1'b1;
            done_word  = align_word(shreg_q, cnt_q);
            cnt_d      = CNT_ONE;
            shreg_d    = {{(SAMPLE_BITS-1){1'b0}}, sd_smp};
            ch_d       = ws_eff;
          end else begin
            shreg_d = {shreg_q[SAMPLE_BITS-2:0], sd_smp};
            cnt_d   = cnt_q + CNT_ONE;
            if (cnt_q + CNT_ONE == CNT_FULL) begin
              done      = 1'b1;
              done_word = shreg_d;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (slot_edge) begin
            state_d = SHIFT;
            cnt_d   = CNT_ONE;
            shreg_d = {{(SAMPLE_BITS-1){1'b0}}, sd_smp};
            ch_d    = ws_eff;
          end
        end
        default: state_d = SYNC_WAIT;
      endcase
    end
  end

  // Commit stage: left words wait in hold_q until their right partner completes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SYNC_WAIT;
      cnt_q         <= '0;
      shreg_q       <= '0;
      ch_q          <= CH_LEFT;
      ws_prev_q     <= 1'b0;
      ws_eff_prev_q <= 1'b0;
      hold_q        <= '0;
      hold_vld_q    <= 1'b0;
      left_data     <= '0;
      right_data    <= '0;
      sample_valid  <= 1'b0;
      short_slot    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      ch_q         <= ch_d;
      sample_valid <= 1'b0;
      short_slot   <= done_short;
      if (sck_rise) begin
        ws_prev_q     <= ws_smp;
        ws_eff_prev_q <= ws_eff;
      end
      if (done) begin
        if (done_ch == CH_LEFT) begin
          hold_q     <= done_word;
          hold_vld_q <= 1'b1;
        end else if (hold_vld_q) begin
          left_data    <= hold_q;
          right_data   <= done_word;
          sample_valid <= 1'b1;
          hold_vld_q   <= 1'b0;
        end
      end
    end
  end

endmodule
